// File: rtl/counter_sequence_checker.sv
// Sequence monitor for a free-running up-counter: locks onto a +1 run, then flags
// skips, repeats and jumps, counts wraps and reports stalls. All outputs are registered.
module counter_sequence_checker #(
    parameter int WIDTH       = 4,
    parameter int LOCK_CYCLES = 4,
    parameter int STALL_MAX   = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] cnt_in,
    input  logic             cnt_valid,
    input  logic             clr_err,
    output logic             locked,
    output logic             err_pulse,
    output logic             err_sticky,
    output logic [7:0]       err_count,
    output logic [7:0]       wrap_count,
    output logic [WIDTH-1:0] last_bad,
    output logic             stall
);

    typedef enum logic [1:0] {IDLE, ACQ, LOCKED} state_e;

    localparam logic [WIDTH-1:0] MAX_VAL   = '1;
    localparam logic [3:0]       LOCK_TGT  = LOCK_CYCLES[3:0];
    localparam logic [7:0]       STALL_TGT = STALL_MAX[7:0];

    state_e           state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [3:0]       match_run_q, match_run_d;
    logic [7:0]       idle_run_q, idle_run_d;
    logic             locked_q, locked_d;
    logic             err_pulse_q, err_pulse_d;
    logic             err_sticky_q, err_sticky_d;
    logic [7:0]       err_count_q, err_count_d;
    logic [7:0]       wrap_count_q, wrap_count_d;
    logic [WIDTH-1:0] last_bad_q, last_bad_d;
    logic             stall_q, stall_d;

    logic [WIDTH-1:0] exp_val;
    logic             is_match;

    function automatic logic [7:0] satInc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign exp_val  = prev_q + WIDTH'(1);
    assign is_match = (cnt_in == exp_val);

    // clr_err is applied first so a same-edge error or wrap counts on top of a cleared value.
    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        match_run_d  = match_run_q;
        idle_run_d   = idle_run_q;
        locked_d     = locked_q;
        err_pulse_d  = 1'b0;
        err_sticky_d = err_sticky_q;
        err_count_d  = err_count_q;
        wrap_count_d = wrap_count_q;
        last_bad_d   = last_bad_q;
        stall_d      = 1'b0;

        if (clr_err) begin
            err_sticky_d = 1'b0;
            err_count_d  = 8'd0;
            wrap_count_d = 8'd0;
            last_bad_d   = '0;
        end

        if (cnt_valid) begin
            prev_d     = cnt_in;
            idle_run_d = 8'd0;
            unique case (state_q)
                IDLE: begin
                    match_run_d = 4'd0;
                    state_d     = ACQ;
                end
                ACQ: begin
                    if (is_match) begin
                        match_run_d = match_run_q + 4'd1;
                        if (match_run_q + 4'd1 == LOCK_TGT) begin
                            state_d  = LOCKED;
                            locked_d = 1'b1;
                        end
                    end else begin
                        match_run_d = 4'd0;
                    end
                end
                LOCKED: begin
                    if (is_match) begin
                        if (prev_q == MAX_VAL) begin
                            wrap_count_d = satInc(wrap_count_d);
                        end
                    end else begin
                        err_pulse_d  = 1'b1;
                        err_sticky_d = 1'b1;
                        err_count_d  = satInc(err_count_d);
                        last_bad_d   = cnt_in;
                        state_d      = ACQ;
                        match_run_d  = 4'd0;
                        locked_d     = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q == LOCKED) begin
            idle_run_d = idle_run_q + 8'd1;
            if (idle_run_q + 8'd1 == STALL_TGT) begin
                stall_d    = 1'b1;
                locked_d   = 1'b0;
                state_d    = IDLE;
                idle_run_d = 8'd0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            prev_q       <= '0;
            match_run_q  <= 4'd0;
            idle_run_q   <= 8'd0;
            locked_q     <= 1'b0;
            err_pulse_q  <= 1'b0;
            err_sticky_q <= 1'b0;
            err_count_q  <= 8'd0;
            wrap_count_q <= 8'd0;
            last_bad_q   <= '0;
            stall_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            match_run_q  <= match_run_d;
            idle_run_q   <= idle_run_d;
            locked_q     <= locked_d;
            err_pulse_q  <= err_pulse_d;
            err_sticky_q <= err_sticky_d;
            err_count_q  <= err_count_d;
            wrap_count_q <= wrap_count_d;
            last_bad_q   <= last_bad_d;
            stall_q      <= stall_d;
        end
    end

    assign locked     = locked_q;
    assign err_pulse  = err_pulse_q;
    assign err_sticky = err_sticky_q;
    assign err_count  = err_count_q;
    assign wrap_count = wrap_count_q;
    assign last_bad   = last_bad_q;
    assign stall      = stall_q;

endmodule

// File: tb/tb_counter_sequence_checker.sv
// Scoreboard bench for counter_sequence_checker: directed vectors push expected
// snapshots, a monitor pops one per clock edge and compares.
module tb_counter_sequence_checker;

    typedef struct {
        string      tag;
        logic       lk;
        logic       pl;
        logic       sk;
        logic       st;
        logic [7:0] ec;
        logic [7:0] wc;
        logic [3:0] lb;
    } exp_t;

    logic       clk;
    logic       rstn;
    logic [3:0] cnt_in;
    logic       cnt_valid;
    logic       clr_err;
    logic       locked;
    logic       err_pulse;
    logic       err_sticky;
    logic [7:0] err_count;
    logic [7:0] wrap_count;
    logic [3:0] last_bad;
    logic       stall;

    exp_t sbQ[$];
    int   vecCount  = 0;
    int   missCount = 0;

    logic       eLocked;
    logic       eSticky;
    logic [7:0] eErrCnt;
    logic [7:0] eWrap;
    logic [3:0] eLastBad;

    counter_sequence_checker #(.WIDTH(4), .LOCK_CYCLES(4), .STALL_MAX(8)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .cnt_in     (cnt_in),
        .cnt_valid  (cnt_valid),
        .clr_err    (clr_err),
        .locked     (locked),
        .err_pulse  (err_pulse),
        .err_sticky (err_sticky),
        .err_count  (err_count),
        .wrap_count (wrap_count),
        .last_bad   (last_bad),
        .stall      (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input exp_t e);
        vecCount++;
        if (locked !== e.lk || err_pulse !== e.pl || err_sticky !== e.sk || stall !== e.st ||
            err_count !== e.ec || wrap_count !== e.wc || last_bad !== e.lb) begin
            missCount++;
            $display("[TB] FAIL %s: got lk=%0b pl=%0b sk=%0b st=%0b ec=%0d wc=%0d lb=%0d, expected lk=%0b pl=%0b sk=%0b st=%0b ec=%0d wc=%0d lb=%0d",
                     e.tag, locked, err_pulse, err_sticky, stall, err_count, wrap_count, last_bad,
                     e.lk, e.pl, e.sk, e.st, e.ec, e.wc, e.lb);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [3:0] val, input logic clr,
                                 input logic expPulse, input logic expStall, input string tag);
        exp_t e;
        @(negedge clk);
        cnt_valid = v;
        cnt_in    = val;
        clr_err   = clr;
        e.tag = tag;
        e.lk  = eLocked;
        e.pl  = expPulse;
        e.sk  = eSticky;
        e.st  = expStall;
        e.ec  = eErrCnt;
        e.wc  = eWrap;
        e.lb  = eLastBad;
        sbQ.push_back(e);
    endtask

    task automatic sendV(input logic [3:0] val, input string tag);
        applyStimulus(1'b1, val, 1'b0, 1'b0, 1'b0, tag);
    endtask

    task automatic idleCycle(input string tag);
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, tag);
    endtask

    task automatic clearExpected();
        eLocked  = 1'b0;
        eSticky  = 1'b0;
        eErrCnt  = 8'd0;
        eWrap    = 8'd0;
        eLastBad = 4'd0;
    endtask

    // Monitor: one expected snapshot per rising edge, sampled just after it.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sbQ.size() > 0) begin
                checkOutput(sbQ.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        exp_t z;
        logic [3:0] p;
        logic [3:0] bad;

        rstn      = 1'b0;
        cnt_valid = 1'b0;
        cnt_in    = 4'd0;
        clr_err   = 1'b0;
        clearExpected();
        z.tag = "reset"; z.lk = 0; z.pl = 0; z.sk = 0; z.st = 0; z.ec = 0; z.wc = 0; z.lb = 0;
        repeat (3) @(negedge clk);
        checkOutput(z);
        rstn = 1'b1;

        // Acquire and lock on 0..4.
        for (int v = 0; v < 4; v++) sendV(4'(v), "acq");
        eLocked = 1'b1;
        sendV(4'd4, "lock");
        for (int v = 5; v < 16; v++) sendV(4'(v), "run");
        eWrap = 8'd1;
        sendV(4'd0, "wrap");
        sendV(4'd1, "postWrap");

        // Source reset to 0 while locked at 6.
        for (int v = 2; v < 7; v++) sendV(4'(v), "run6");
        eLocked = 1'b0; eSticky = 1'b1; eErrCnt = 8'd1; eLastBad = 4'd0;
        applyStimulus(1'b1, 4'd0, 1'b0, 1'b1, 1'b0, "srcReset");
        sendV(4'd0, "repeat0a");
        sendV(4'd0, "repeat0b");
        for (int v = 1; v < 4; v++) sendV(4'(v), "reacq");
        eLocked = 1'b1;
        sendV(4'd4, "relock");

        // Seven idle cycles are tolerated, eight declare a stall.
        repeat (7) idleCycle("idle7");
        sendV(4'd5, "noStall");
        repeat (7) idleCycle("idle8");
        eLocked = 1'b0;
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, "stall");
        idleCycle("idleHold");
        for (int v = 0; v < 4; v++) sendV(4'(v), "reacqStall");
        eLocked = 1'b1;
        sendV(4'd4, "relockStall");

        // Build err_count up to 3, then clear on the same edge as a skip.
        eLocked = 1'b0; eErrCnt = 8'd2; eLastBad = 4'd6;
        applyStimulus(1'b1, 4'd6, 1'b0, 1'b1, 1'b0, "skip2");
        for (int v = 7; v < 10; v++) sendV(4'(v), "reacq2");
        eLocked = 1'b1;
        sendV(4'd10, "relock2");
        eLocked = 1'b0; eErrCnt = 8'd3; eLastBad = 4'd12;
        applyStimulus(1'b1, 4'd12, 1'b0, 1'b1, 1'b0, "skip3");
        for (int v = 13; v < 16; v++) sendV(4'(v), "reacq3");
        eLocked = 1'b1;
        sendV(4'd0, "relockAcqWrap");
        for (int v = 1; v < 6; v++) sendV(4'(v), "run5");
        eLocked = 1'b0; eErrCnt = 8'd1; eLastBad = 4'd7; eWrap = 8'd0; eSticky = 1'b1;
        applyStimulus(1'b1, 4'd7, 1'b1, 1'b1, 1'b0, "clrAndErr");
        eSticky = 1'b0; eErrCnt = 8'd0; eLastBad = 4'd0;
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, "clrAlone");
        for (int v = 8; v < 11; v++) sendV(4'(v), "reacq4");
        eLocked = 1'b1;
        sendV(4'd11, "relock4");
        for (int v = 12; v < 16; v++) sendV(4'(v), "run15");
        eWrap = 8'd1;
        applyStimulus(1'b1, 4'd0, 1'b1, 1'b0, 1'b0, "clrAndWrap");

        // 300 errors via skip/relock; counter must saturate at 255.
        p = 4'd0;
        for (int k = 1; k <= 300; k++) begin
            bad = p + 4'd2;
            eLocked = 1'b0; eSticky = 1'b1; eLastBad = bad;
            eErrCnt = (k > 255) ? 8'd255 : 8'(k);
            applyStimulus(1'b1, bad, 1'b0, 1'b1, 1'b0, "satErr");
            for (int j = 1; j < 4; j++) sendV(bad + 4'(j), "satReacq");
            eLocked = 1'b1;
            sendV(bad + 4'd4, "satRelock");
            p = bad + 4'd4;
        end

        // Asynchronous reset between edges.
        @(posedge clk);
        #3;
        rstn = 1'b0;
        #1;
        z.tag = "asyncReset";
        checkOutput(z);
        @(negedge clk);
        cnt_valid = 1'b0;
        clr_err   = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        clearExpected();
        sendV(4'd3, "postReset");

        for (int i = 0; i < 10 && sbQ.size() > 0; i++) @(negedge clk);
        if (sbQ.size() > 0) begin
            missCount++;
            $display("[TB] FAIL drain: %0d expected entries left, required 0", sbQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
